ula_seq16: RTL and testbench

Nibble-serial sequencer that performs W-bit operations (default 16) on one shared `ula_74181` 4-bit slice. Operations are executed one nibble per cycle, LSB nibble first. Carry ripples through an internal register between nibbles, and the slice's equality output is accumulated across all nibbles. It sits between a requester (valid/ready) and the ALU slice and replaces a parallel chain of 74181s where area matters.

---
 rtl/ula_pkg.sv | 13 +
 rtl/ula_74181.sv | 35 +++
 rtl/ula_seq16.sv | 136 +++++++++++++
 tb/tb_ula_seq16.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
package ula_pkg;

  localparam int unsigned ULA_SLICE_W     = 4;
  localparam int unsigned ULA_MAX_NIBBLES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ula_seq_state_t;

endpackage

// File: rtl/ula_74181.sv
// 4-bit 74181 ALU slice, active-high data, active-low carry in/out.
module ula_74181
  import ula_pkg::*;
(
  input  logic [ULA_SLICE_W-1:0] a,
  input  logic [ULA_SLICE_W-1:0] b,
  input  logic [3:0]             s,
  input  logic                   m,
  input  logic                   c_in,
  output logic [ULA_SLICE_W-1:0] f,
  output logic                   c_out,
  output logic                   a_eq_b,
  output logic                   p,
  output logic                   g
);

  logic [ULA_SLICE_W-1:0] x;
  logic [ULA_SLICE_W-1:0] y;
  logic [ULA_SLICE_W:0]   sum;
  logic [ULA_SLICE_W:0]   gen_sum;

  // Select-gated operand terms; arithmetic is x + y + carry, logic is xnor(x, y)
  always_comb begin
    x       = a | (b & {ULA_SLICE_W{s[0]}}) | (~b & {ULA_SLICE_W{s[1]}});
    y       = (a & ~b & {ULA_SLICE_W{s[2]}}) | (a & b & {ULA_SLICE_W{s[3]}});
    sum     = {1'b0, x} + {1'b0, y} + {{ULA_SLICE_W{1'b0}}, ~c_in};
    gen_sum = {1'b0, x} + {1'b0, y};
    f       = m ? ~(x ^ y) : sum[ULA_SLICE_W-1:0];
    c_out   = ~sum[ULA_SLICE_W];
    a_eq_b  = &f;
    g       = ~gen_sum[ULA_SLICE_W];
    p       = ~(&(x | y));
  end

endmodule

// File: rtl/ula_seq16.sv
// Nibble-serial sequencer running W-bit 74181 operations on one shared slice.
module ula_seq16
  import ula_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ULA_SLICE_W*NIBBLES-1:0]  req_a,
  input  logic [ULA_SLICE_W*NIBBLES-1:0]  req_b,
  input  logic [3:0]                      req_s,
  input  logic                            req_m,
  input  logic                            req_c_in,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ULA_SLICE_W*NIBBLES-1:0]  rsp_f,
  output logic                            rsp_c_out,
  output logic                            rsp_a_eq_b,
  output logic                            rsp_zero,
  output logic                            busy
);

  localparam int unsigned W     = ULA_SLICE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? int'($clog2(NIBBLES)) : 1;
  localparam int unsigned LAST  = NIBBLES - 1;

  ula_seq_state_t state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [W-1:0]           a_lat, b_lat, f_reg, f_next;
  logic [3:0]             s_lat;
  logic                   m_lat, carry_reg, eq_reg, zero_reg;
  logic                   accept, step, last;
  logic [ULA_SLICE_W-1:0] slice_a, slice_b, slice_f;
  logic                   slice_c_out, slice_eq;
  logic                   slice_p_unused, slice_g_unused;

  assign last = (idx_q == IDX_W'(LAST));

  // Next-state and step/accept strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with handshake outputs registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Route the current nibble to the slice and merge its result into f
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    f_next  = f_reg;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (idx_q == IDX_W'(k)) begin
        slice_a = a_lat[k*ULA_SLICE_W +: ULA_SLICE_W];
        slice_b = b_lat[k*ULA_SLICE_W +: ULA_SLICE_W];
        f_next[k*ULA_SLICE_W +: ULA_SLICE_W] = slice_f;
      end
    end
  end

  // Operand latches, nibble index, carry/eq accumulation and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat     <= '0;
      b_lat     <= '0;
      s_lat     <= '0;
      m_lat     <= 1'b0;
      carry_reg <= 1'b0;
      eq_reg    <= 1'b0;
      idx_q     <= '0;
      f_reg     <= '0;
      zero_reg  <= 1'b1;
    end else if (accept) begin
      a_lat     <= req_a;
      b_lat     <= req_b;
      s_lat     <= req_s;
      m_lat     <= req_m;
      carry_reg <= req_c_in;
      eq_reg    <= 1'b1;
      idx_q     <= '0;
    end else if (step) begin
      f_reg     <= f_next;
      zero_reg  <= ~|f_next;
      carry_reg <= slice_c_out;
      eq_reg    <= eq_reg & slice_eq;
      idx_q     <= last ? '0 : idx_q + IDX_W'(1);
    end
  end

  ula_74181 u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .s      (s_lat),
    .m      (m_lat),
    .c_in   (carry_reg),
    .f      (slice_f),
    .c_out  (slice_c_out),
    .a_eq_b (slice_eq),
    .p      (slice_p_unused),
    .g      (slice_g_unused)
  );

  assign rsp_f      = f_reg;
  assign rsp_c_out  = carry_reg;
  assign rsp_a_eq_b = eq_reg;
  assign rsp_zero   = zero_reg;

endmodule

// File: tb/tb_ula_seq16.sv
// Directed and random checks of ula_seq16 at NIBBLES=4 and NIBBLES=1.
module tb_ula_seq16;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_m, req_c_in, rsp_valid, rsp_ready;
  logic [15:0] req_a, req_b, rsp_f;
  logic [3:0]  req_s;
  logic        rsp_c_out, rsp_a_eq_b, rsp_zero, busy;

  logic        req_valid_n1, req_ready_n1, req_m_n1, req_c_in_n1, rsp_valid_n1, rsp_ready_n1;
  logic [3:0]  req_a_n1, req_b_n1, req_s_n1, rsp_f_n1;
  logic        rsp_c_out_n1, rsp_a_eq_b_n1, rsp_zero_n1, busy_n1;

  int checks = 0;
  int fails  = 0;

  ula_seq16 #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_c_out(rsp_c_out),
    .rsp_a_eq_b(rsp_a_eq_b), .rsp_zero(rsp_zero), .busy(busy)
  );

  ula_seq16 #(.NIBBLES(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_n1), .req_ready(req_ready_n1),
    .req_a(req_a_n1), .req_b(req_b_n1), .req_s(req_s_n1), .req_m(req_m_n1),
    .req_c_in(req_c_in_n1), .rsp_valid(rsp_valid_n1), .rsp_ready(rsp_ready_n1),
    .rsp_f(rsp_f_n1), .rsp_c_out(rsp_c_out_n1), .rsp_a_eq_b(rsp_a_eq_b_n1),
    .rsp_zero(rsp_zero_n1), .busy(busy_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One 74181 nibble written from the function table (arith: o1 + o2 + carry)
  task automatic nib_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                           input logic m, input logic cin,
                           output logic [3:0] f, output logic co, output logic eq);
    logic [4:0] o1, o2, r;
    logic [3:0] lf;
    case (s)
      4'h0: begin o1 = {1'b0, a};       o2 = 5'h00;            lf = ~a;        end
      4'h1: begin o1 = {1'b0, a | b};   o2 = 5'h00;            lf = ~(a | b);  end
      4'h2: begin o1 = {1'b0, a | ~b};  o2 = 5'h00;            lf = ~a & b;    end
      4'h3: begin o1 = 5'h0F;           o2 = 5'h00;            lf = 4'h0;      end
      4'h4: begin o1 = {1'b0, a};       o2 = {1'b0, a & ~b};   lf = ~(a & b);  end
      4'h5: begin o1 = {1'b0, a | b};   o2 = {1'b0, a & ~b};   lf = ~b;        end
      4'h6: begin o1 = {1'b0, a};       o2 = {1'b0, ~b};       lf = a ^ b;     end
      4'h7: begin o1 = {1'b0, a & ~b};  o2 = 5'h0F;            lf = a & ~b;    end
      4'h8: begin o1 = {1'b0, a};       o2 = {1'b0, a & b};    lf = ~a | b;    end
      4'h9: begin o1 = {1'b0, a};       o2 = {1'b0, b};        lf = ~(a ^ b);  end
      4'hA: begin o1 = {1'b0, a | ~b};  o2 = {1'b0, a & b};    lf = b;         end
      4'hB: begin o1 = {1'b0, a & b};   o2 = 5'h0F;            lf = a & b;     end
      4'hC: begin o1 = {1'b0, a};       o2 = {1'b0, a};        lf = 4'hF;      end
      4'hD: begin o1 = {1'b0, a | b};   o2 = {1'b0, a};        lf = a | ~b;    end
      4'hE: begin o1 = {1'b0, a | ~b};  o2 = {1'b0, a};        lf = a | b;     end
      default: begin o1 = {1'b0, a};    o2 = 5'h0F;            lf = a;         end
    endcase
    r  = o1 + o2 + {4'b0, ~cin};
    f  = m ? lf : r[3:0];
    co = ~r[4];
    eq = (f == 4'hF);
  endtask

  // Parallel chain of n nibbles: carry rippled, equality ANDed
  task automatic golden(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic cin,
                        output logic [15:0] f, output logic co, output logic eq, output logic z);
    logic       c, cn, en;
    logic [3:0] fn;
    f  = '0;
    c  = cin;
    eq = 1'b1;
    for (int k = 0; k < n; k++) begin
      nib_model(4'(a >> (4*k)), 4'(b >> (4*k)), s, m, c, fn, cn, en);
      f  = f | (16'(fn) << (4*k));
      c  = cn;
      eq = eq & en;
    end
    co = c;
    z  = (f == 16'h0);
  endtask

  // Issue one request to the 4-nibble DUT and collect its response
  task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin, input int stall,
                         output logic [15:0] f, output logic co, output logic eq,
                         output logic z, output int lat);
    int w;
    @(negedge clk);
    req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin;
    req_valid = 1'b1; rsp_ready = 1'b0;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (!rsp_valid) begin
      fails++;
      $display("FAIL rsp_timeout_n4: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
    end
    repeat (stall) @(negedge clk);
    f = rsp_f; co = rsp_c_out; eq = rsp_a_eq_b; z = rsp_zero;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Issue one request to the 1-nibble DUT and collect its response
  task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                         input logic m, input logic cin, input int stall,
                         output logic [3:0] f, output logic co, output logic eq,
                         output logic z, output int lat);
    int w;
    @(negedge clk);
    req_a_n1 = a; req_b_n1 = b; req_s_n1 = s; req_m_n1 = m; req_c_in_n1 = cin;
    req_valid_n1 = 1'b1; rsp_ready_n1 = 1'b0;
    w = 0;
    while (!req_ready_n1 && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid_n1 = 1'b0;
    lat = 0;
    while (!rsp_valid_n1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (!rsp_valid_n1) begin
      fails++;
      $display("FAIL rsp_timeout_n1: rsp_valid=%b after %0d cycles, required 1", rsp_valid_n1, lat);
    end
    repeat (stall) @(negedge clk);
    f = rsp_f_n1; co = rsp_c_out_n1; eq = rsp_a_eq_b_n1; z = rsp_zero_n1;
    rsp_ready_n1 = 1'b1;
    @(negedge clk);
    rsp_ready_n1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; rsp_ready = 0; req_a = '0; req_b = '0; req_s = '0; req_m = 0; req_c_in = 0;
    req_valid_n1 = 0; rsp_ready_n1 = 0; req_a_n1 = '0; req_b_n1 = '0; req_s_n1 = '0;
    req_m_n1 = 0; req_c_in_n1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      fails++; $display("FAIL reset_hs: ready/valid/busy=%b, required 100", {req_ready, rsp_valid, busy});
    end
    checks++;
    if (rsp_f !== 16'h0) begin fails++; $display("FAIL reset_f: got %h, required 0000", rsp_f); end
    checks++;
    if ({rsp_c_out, rsp_a_eq_b, rsp_zero} !== 3'b001) begin
      fails++; $display("FAIL reset_flags: c/eq/zero=%b, required 001", {rsp_c_out, rsp_a_eq_b, rsp_zero});
    end
    checks++;
    if ({req_ready_n1, rsp_valid_n1, busy_n1, rsp_zero_n1} !== 4'b1001) begin
      fails++; $display("FAIL reset_n1: ready/valid/busy/zero=%b, required 1001",
                        {req_ready_n1, rsp_valid_n1, busy_n1, rsp_zero_n1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      fails++; $display("FAIL post_reset_hs: ready/valid/busy=%b, required 100", {req_ready, rsp_valid, busy});
    end
  endtask

  task automatic test_logic_pass();
    logic [15:0] f, ef; logic co, eq, z, eco, eeq, ez; int lat;
    golden(4, 16'h1234, 16'hFFFF, 4'hF, 1'b1, 1'b1, ef, eco, eeq, ez);
    run_op4(16'h1234, 16'hFFFF, 4'hF, 1'b1, 1'b1, 0, f, co, eq, z, lat);
    checks++;
    if (f !== 16'h1234) begin fails++; $display("FAIL pass_f: got %h, required 1234", f); end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL pass_latency: got %0d, required 4", lat); end
    checks++;
    if ({co, eq, z} !== {eco, eeq, ez}) begin
      fails++; $display("FAIL pass_flags: c/eq/zero=%b, required %b", {co, eq, z}, {eco, eeq, ez});
    end
  endtask

  task automatic test_logic_not();
    logic [15:0] f, ef; logic co, eq, z, eco, eeq, ez; int lat;
    golden(4, 16'hA5F0, 16'h0000, 4'h0, 1'b1, 1'b1, ef, eco, eeq, ez);
    run_op4(16'hA5F0, 16'h0000, 4'h0, 1'b1, 1'b1, 1, f, co, eq, z, lat);
    checks++;
    if (f !== 16'h5A0F) begin fails++; $display("FAIL not_f: got %h, required 5a0f", f); end
    checks++;
    if ({co, eq, z} !== {eco, eeq, 1'b0}) begin
      fails++; $display("FAIL not_flags: c/eq/zero=%b, required %b", {co, eq, z}, {eco, eeq, 1'b0});
    end
  endtask

  task automatic test_carry();
    logic [15:0] f, ef; logic co, eq, z, eco, eeq, ez; int lat;
    golden(4, 16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b1, ef, eco, eeq, ez);
    run_op4(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b1, 0, f, co, eq, z, lat);
    checks++;
    if (f !== 16'h0100) begin fails++; $display("FAIL carry_f: got %h, required 0100", f); end
    checks++;
    if ({co, eq, z} !== {eco, eeq, ez} || co !== 1'b1) begin
      fails++; $display("FAIL carry_flags: c/eq/zero=%b, required %b", {co, eq, z}, {eco, eeq, ez});
    end
  endtask

  task automatic test_eq_zero();
    logic [15:0] f; logic co, eq, z; int lat;
    // A minus B minus 1 with A == B gives FFFF: every nibble asserts a_eq_b
    run_op4(16'h3C5A, 16'h3C5A, 4'h6, 1'b0, 1'b1, 0, f, co, eq, z, lat);
    checks++;
    if ({f, co, eq, z} !== {16'hFFFF, 3'b110}) begin
      fails++; $display("FAIL eq_all: f=%h c/eq/zero=%b, required ffff 110", f, {co, eq, z});
    end
    // Logic zero function: rsp_zero must assert
    run_op4(16'hBEEF, 16'h1234, 4'h3, 1'b1, 1'b1, 2, f, co, eq, z, lat);
    checks++;
    if ({f, eq, z} !== {16'h0000, 2'b01}) begin
      fails++; $display("FAIL zero_out: f=%h eq/zero=%b, required 0000 01", f, {eq, z});
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ef; logic eco, eeq, ez; int w;
    golden(4, 16'h1111, 16'h2222, 4'h9, 1'b0, 1'b1, ef, eco, eeq, ez);
    @(negedge clk);
    req_a = 16'h1111; req_b = 16'h2222; req_s = 4'h9; req_m = 1'b0; req_c_in = 1'b1;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req_a = 16'h0F0F; req_b = 16'h0101;
    w = 0;
    while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, req_ready, busy, rsp_f, rsp_c_out, rsp_a_eq_b, rsp_zero} !==
          {3'b101, ef, eco, eeq, ez}) begin
        fails++; $display("FAIL bp_hold[%0d]: v/rdy/busy=%b f=%h, required 101 f=%h",
                          i, {rsp_valid, req_ready, busy}, rsp_f, ef);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      fails++; $display("FAIL bp_after_hs: rdy/v/busy=%b, required 100", {req_ready, rsp_valid, busy});
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({req_ready, busy} !== 2'b01) begin
      fails++; $display("FAIL bp_second_accept: rdy/busy=%b, required 01", {req_ready, busy});
    end
    w = 0;
    while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
    checks++;
    if ({rsp_valid, rsp_f} !== {1'b1, 16'h1010}) begin
      fails++; $display("FAIL bp_second_f: v=%b f=%h, required 1 1010", rsp_valid, rsp_f);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] f, ef; logic co, eq, z, eco, eeq, ez; int lat;
    @(negedge clk);
    req_a = 16'hFFFF; req_b = 16'hFFFF; req_s = 4'h9; req_m = 1'b0; req_c_in = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_zero, rsp_f} !== {4'b0011, 16'h0}) begin
      fails++; $display("FAIL midreset: v/busy/rdy/zero=%b f=%h, required 0011 0000",
                        {rsp_valid, busy, req_ready, rsp_zero}, rsp_f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    golden(4, 16'h7E21, 16'h0AB3, 4'h9, 1'b0, 1'b0, ef, eco, eeq, ez);
    run_op4(16'h7E21, 16'h0AB3, 4'h9, 1'b0, 1'b0, 0, f, co, eq, z, lat);
    checks++;
    if ({f, co, eq, z} !== {ef, eco, eeq, ez} || f !== 16'h88D5) begin
      fails++; $display("FAIL after_midreset: f=%h c/eq/z=%b, required %h %b", f, {co, eq, z}, ef, {eco, eeq, ez});
    end
  endtask

  task automatic test_random4();
    logic [15:0] a, b, f, ef; logic [3:0] s; logic m, cin, co, eq, z, eco, eeq, ez; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom);
      m = 1'($urandom); cin = 1'($urandom);
      golden(4, a, b, s, m, cin, ef, eco, eeq, ez);
      run_op4(a, b, s, m, cin, int'($urandom_range(0, 3)), f, co, eq, z, lat);
      checks++;
      if ({f, co, eq, z} !== {ef, eco, eeq, ez}) begin
        fails++; $display("FAIL rand4[%0d] a=%h b=%h s=%h m=%b c=%b: f=%h c/eq/z=%b, required %h %b",
                          i, a, b, s, m, cin, f, {co, eq, z}, ef, {eco, eeq, ez});
      end
    end
  endtask

  task automatic test_random1();
    logic [15:0] ef; logic [3:0] a, b, s, f; logic m, cin, co, eq, z, eco, eeq, ez; int lat;
    run_op1(4'h7, 4'h9, 4'h9, 1'b0, 1'b1, 0, f, co, eq, z, lat);
    checks++;
    if ({lat, f, co, eq, z} !== {32'd1, 4'h0, 3'b001}) begin
      fails++; $display("FAIL n1_direct: lat=%0d f=%h c/eq/z=%b, required 1 0 001", lat, f, {co, eq, z});
    end
    for (int i = 0; i < 1000; i++) begin
      a = 4'($urandom); b = 4'($urandom); s = 4'($urandom);
      m = 1'($urandom); cin = 1'($urandom);
      golden(1, {12'h0, a}, {12'h0, b}, s, m, cin, ef, eco, eeq, ez);
      run_op1(a, b, s, m, cin, int'($urandom_range(0, 3)), f, co, eq, z, lat);
      checks++;
      if ({f, co, eq, z} !== {ef[3:0], eco, eeq, ez}) begin
        fails++; $display("FAIL rand1[%0d] a=%h b=%h s=%h m=%b c=%b: f=%h c/eq/z=%b, required %h %b",
                          i, a, b, s, m, cin, f, {co, eq, z}, ef[3:0], {eco, eeq, ez});
      end
    end
  endtask

  initial begin
    test_reset();
    test_logic_pass();
    test_logic_not();
    test_carry();
    test_eq_zero();
    test_backpressure();
    test_reset_mid();
    test_random4();
    test_random1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
